// File: rtl/prediction_letter_streamer.sv
// rtl/prediction_letter_streamer.sv - debounces class predictions and streams committed classes as ASCII bytes
module prediction_letter_streamer #(
  parameter int CLASS_W      = 6,
  parameter int NUM_CLASSES  = 25,
  parameter int STABLE_COUNT = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int APPEND_NL    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [CLASS_W-1:0]            in_class,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_char,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          committed_valid,
  output logic [CLASS_W-1:0]            committed_class,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(STABLE_COUNT + 1);
  localparam logic [RW-1:0] STABLE_V = RW'(STABLE_COUNT);
  localparam logic [CW-1:0] NEED     = CW'(1 + APPEND_NL);
  localparam logic [AW-1:0] NEED_PTR = AW'(1 + APPEND_NL);

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [CW-1:0]      count_q, count_d;
  logic [CLASS_W-1:0] cand_q, cand_d;
  logic               cand_valid_q, cand_valid_d;
  logic [RW-1:0]      run_q, run_d;
  logic [CLASS_W-1:0] committed_class_q;
  logic               committed_valid_q, overflow_q;

  logic       match, saturated, commit, push_ok, pop;
  logic [7:0] letter;
  logic [CW-1:0] free_slots;

  always_comb begin
    match        = cand_valid_q && (in_class == cand_q);
    saturated    = (run_q == STABLE_V);
    cand_d       = cand_q;
    cand_valid_d = cand_valid_q;
    run_d        = run_q;
    commit       = 1'b0;
    if (in_valid) begin
      cand_d       = in_class;
      cand_valid_d = 1'b1;
      if (match) begin
        if (!saturated) run_d = run_q + 1'b1;
      end else begin
        run_d = RW'(1);
      end
      // A saturated run re-hitting the threshold is not a new arrival.
      commit = (run_d == STABLE_V) && !(match && saturated) &&
               (!committed_valid_q || (in_class != committed_class_q));
    end
  end

  always_comb begin
    if (int'(in_class) < NUM_CLASSES) letter = 8'h41 + 8'(in_class);
    else                              letter = 8'h3F;
    free_slots = CW'(FIFO_DEPTH) - count_q;
    push_ok    = commit && (free_slots >= NEED);
    pop        = (count_q != '0) && out_ready;
    count_d    = count_q + (push_ok ? NEED : '0) - (pop ? CW'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q              <= '0;
      rd_q              <= '0;
      count_q           <= '0;
      cand_q            <= '0;
      cand_valid_q      <= 1'b0;
      run_q             <= '0;
      committed_class_q <= '0;
      committed_valid_q <= 1'b0;
      overflow_q        <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      cand_valid_q <= cand_valid_d;
      run_q        <= run_d;
      count_q      <= count_d;
      if (push_ok) wr_q <= wr_q + NEED_PTR;
      if (pop)     rd_q <= rd_q + AW'(1);
      if (commit) begin
        committed_class_q <= in_class;
        committed_valid_q <= 1'b1;
        if (!push_ok) overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: contents are only visible while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_q] <= letter;
      if (APPEND_NL != 0) mem_q[wr_q + AW'(1)] <= 8'h0A;
    end
  end

  assign in_ready        = 1'b1;
  assign out_valid       = (count_q != '0);
  assign out_char        = out_valid ? mem_q[rd_q] : 8'h00;
  assign fifo_count      = count_q;
  assign committed_valid = committed_valid_q;
  assign committed_class = committed_class_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_prediction_letter_streamer.sv
// tb/tb_prediction_letter_streamer.sv - randomized and directed bench against a history-based reference model
module tb_prediction_letter_streamer;

  localparam int S     = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] in_class = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_char;
  logic [3:0] fifo_count;
  logic       committed_valid;
  logic [5:0] committed_class;
  logic       overflow;

  prediction_letter_streamer #(
    .CLASS_W(6), .NUM_CLASSES(25), .STABLE_COUNT(S), .FIFO_DEPTH(DEPTH), .APPEND_NL(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_class(in_class), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .fifo_count(fifo_count),
    .committed_valid(committed_valid), .committed_class(committed_class), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         hist[$];
  logic [7:0] mq[$];
  bit         m_cv;
  int         m_cc;
  bit         m_ov;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    mq.delete();
    m_cv = 0;
    m_cc = 0;
    m_ov = 0;
  endtask

  // Drive one cycle of inputs, check the state visible before its edge, advance the model.
  task automatic step(input bit r, input bit v, input int cls, input bit rdy);
    int  run_len;
    int  free;
    bit  do_pop;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_class  = cls[5:0];
    out_ready = rdy;
    check_eq("in_ready", 32'(in_ready), 32'd1);
    check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check_eq("out_char", 32'(out_char), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check_eq("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check_eq("committed_valid", 32'(committed_valid), 32'(m_cv));
    check_eq("committed_class", 32'(committed_class), 32'(m_cc));
    check_eq("overflow", 32'(overflow), 32'(m_ov));
    if (r) begin
      model_clear();
    end else begin
      do_pop = (mq.size() != 0) && rdy;
      free   = DEPTH - mq.size();
      if (v) begin
        hist.push_back(cls);
        run_len = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == cls; i--) run_len++;
        if (run_len == S && (!m_cv || cls != m_cc)) begin
          if (free >= 2) begin
            mq.push_back((cls < 25) ? 8'(65 + cls) : 8'h3F);
            mq.push_back(8'h0A);
          end else begin
            m_ov = 1;
          end
          m_cv = 1;
          m_cc = cls;
        end
      end
      if (do_pop) void'(mq.pop_front());
    end
  endtask

  task automatic hold(input int cls, input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 1, cls, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, rdy);
  endtask

  initial begin
    int cls;
    int seq[8] = '{2, 2, 2, 5, 2, 2, 2, 2};
    model_clear();
    repeat (2) @(posedge clk);

    // Basic commit of class 0 with a ready consumer.
    hold(0, 4, 1);
    idle(3, 1);

    // Flicker inside a run must not commit the intruder.
    step(1, 0, 0, 1);
    foreach (seq[i]) step(0, 1, seq[i], 1);
    idle(3, 1);

    // Long hold with gaps commits once.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 24, 1);
      step(0, 0, 24, 1);
    end
    idle(3, 1);

    // Out-of-range class maps to '?'.
    hold(30, 4, 1);
    idle(3, 1);
    check_eq("oor_class", 32'(committed_class), 32'd30);

    // Five commits into a stalled FIFO, then drain.
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) hold(k % 2, 4, 0);
    idle(1, 0);
    check_eq("ovf_count", 32'(fifo_count), 32'd8);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_class", 32'(committed_class), 32'd0);
    idle(10, 1);
    check_eq("drained", 32'(out_valid), 32'd0);

    // Reset mid-run discards bytes and the partial run.
    hold(7, 4, 0);
    hold(3, 3, 0);
    step(1, 0, 0, 0);
    idle(1, 1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_cv", 32'(committed_valid), 32'd0);
    hold(3, 1, 1);
    idle(2, 1);
    check_eq("rst_no_commit", 32'(committed_valid), 32'd0);
    hold(3, 3, 1);
    idle(1, 1);
    check_eq("rst_commit", 32'(out_char), 32'h44);

    // Randomized traffic with sticky classes so runs actually form.
    cls = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0)
        cls = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(23, 31);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, cls,
           $urandom_range(0, 3) != 0);
    end
    idle(12, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
